fifo_sdp_sync: RTL and testbench

Single-clock synchronous FIFO built on an inferred simple-dual-port RAM (one write port, one registered read port) in the clk_a domain. It generalises the plain two-port SRAM wrapper into a managed buffer. It adds pointers with wrap-around, occupancy count, full/empty and programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It is used between the Forth core's stream producers (UART RX, host link) and their consumers.

---
 rtl/fifo_sdp_sync.sv | 78 +++++++
 tb/tb_fifo_sdp_sync.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fifo_sdp_sync.sv
// Single-clock FIFO on an inferred simple-dual-port RAM with a registered read port.
// Occupancy-based flags, sticky overflow/underflow and a synchronous flush.
module fifo_sdp_sync #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  rst,
  input  logic                  clk_a,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_LVL);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;

  // Flags depend only on registered count, so they carry no input paths.
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign afull  = (count >= AFULL_CNT);
  assign aempty = (count <= AEMPTY_CNT);

  assign wr_acc = wr_en & ~full  & ~clr;
  assign rd_acc = rd_en & ~empty & ~clr;

  // RAM array carries no reset so it maps onto block/distributed memory.
  always_ff @(posedge clk_a) begin
    if (wr_acc) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        rdata  <= mem[rd_ptr];
      end
      rvalid    <= rd_acc;
      count     <= count + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
      overflow  <= overflow  | (wr_en & full);
      underflow <= underflow | (rd_en & empty);
    end
  end

endmodule

// File: tb/tb_fifo_sdp_sync.sv
// Directed bench for fifo_sdp_sync at DEPTH=8, WIDTH=16 (afull at 6, aempty at 2).
module tb_fifo_sdp_sync;

  localparam int W = 16;
  localparam int D = 8;
  localparam int AW = 3;

  logic          rst, clk_a, clr, wr_en, rd_en;
  logic [W-1:0]  wdata, rdata;
  logic          rvalid, full, empty, afull, aempty, overflow, underflow;
  logic [AW:0]   count;

  int compared = 0;
  int mismatched = 0;

  fifo_sdp_sync #(.WIDTH(W), .DEPTH(D), .AFULL_LVL(6), .AEMPTY_LVL(2)) dut (
    .rst(rst), .clk_a(clk_a), .clr(clr), .wr_en(wr_en), .wdata(wdata),
    .rd_en(rd_en), .rdata(rdata), .rvalid(rvalid), .count(count),
    .full(full), .empty(empty), .afull(afull), .aempty(aempty),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_a);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); wdata = '0;
    step(); step();
    rst = 1'b0;
    step();
    compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty got %b want 1", empty); end
    compared++; if (full !== 1'b0) begin mismatched++; $display("FAIL reset_full got %b want 0", full); end
    compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", count); end
    compared++; if (aempty !== 1'b1 || afull !== 1'b0) begin mismatched++; $display("FAIL reset_aflags got ae=%b af=%b want ae=1 af=0", aempty, afull); end
    compared++; if (rvalid !== 1'b0 || rdata !== 16'h0) begin mismatched++; $display("FAIL reset_rdata got v=%b d=%h want v=0 d=0000", rvalid, rdata); end
    compared++; if (overflow !== 1'b0 || underflow !== 1'b0) begin mismatched++; $display("FAIL reset_err got o=%b u=%b want 0 0", overflow, underflow); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wdata = 16'(i);
      step();
      compared++; if (count !== 4'(i)) begin mismatched++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
      compared++; if (afull !== (i >= 6)) begin mismatched++; $display("FAIL fill_afull[%0d] got %b want %b", i, afull, (i >= 6)); end
      compared++; if (aempty !== (i <= 2)) begin mismatched++; $display("FAIL fill_aempty[%0d] got %b want %b", i, aempty, (i <= 2)); end
      compared++; if (full !== (i == 8)) begin mismatched++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 8)); end
    end
    wr_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      step();
      compared++; if (rvalid !== 1'b1 || rdata !== 16'(i)) begin mismatched++; $display("FAIL drain_data[%0d] got v=%b d=%h want v=1 d=%h", i, rvalid, rdata, 16'(i)); end
      compared++; if (count !== 4'(8 - i)) begin mismatched++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 8 - i); end
    end
    rd_en = 1'b0;
    step();
    compared++; if (empty !== 1'b1 || rvalid !== 1'b0) begin mismatched++; $display("FAIL drain_end got e=%b v=%b want e=1 v=0", empty, rvalid); end
    compared++; if (rdata !== 16'h0008) begin mismatched++; $display("FAIL drain_hold got %h want 0008", rdata); end
  endtask

  task automatic test_errors();
    for (int i = 1; i <= 8; i++) begin wr_en = 1'b1; wdata = 16'h0020 + 16'(i); step(); end
    wdata = 16'hDEAD;
    step();
    wr_en = 1'b0;
    compared++; if (overflow !== 1'b1 || count !== 4'd8) begin mismatched++; $display("FAIL ovf got o=%b c=%0d want o=1 c=8", overflow, count); end
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      step();
      compared++; if (rdata !== 16'h0020 + 16'(i)) begin mismatched++; $display("FAIL ovf_data[%0d] got %h want %h", i, rdata, 16'h0020 + 16'(i)); end
    end
    compared++; if (underflow !== 1'b0) begin mismatched++; $display("FAIL udf_early got %b want 0", underflow); end
    step();
    rd_en = 1'b0;
    compared++; if (underflow !== 1'b1 || rvalid !== 1'b0) begin mismatched++; $display("FAIL udf got u=%b v=%b want u=1 v=0", underflow, rvalid); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    clr = 1'b1; step(); clr = 1'b0;
    compared++; if (overflow !== 1'b0 || underflow !== 1'b0) begin mismatched++; $display("FAIL err_clr got o=%b u=%b want 0 0", overflow, underflow); end
  endtask

  task automatic test_simul_boundary();
    for (int i = 1; i <= 8; i++) begin wr_en = 1'b1; wdata = 16'h0010 + 16'(i); step(); end
    rd_en = 1'b1; wdata = 16'hBEEF;
    step();
    wr_en = 1'b0;
    compared++; if (count !== 4'd7 || overflow !== 1'b1) begin mismatched++; $display("FAIL simfull got c=%0d o=%b want c=7 o=1", count, overflow); end
    compared++; if (rvalid !== 1'b1 || rdata !== 16'h0011) begin mismatched++; $display("FAIL simfull_data got v=%b d=%h want v=1 d=0011", rvalid, rdata); end
    for (int i = 2; i <= 8; i++) begin
      step();
      compared++; if (rdata !== 16'h0010 + 16'(i)) begin mismatched++; $display("FAIL simfull_drain[%0d] got %h want %h", i, rdata, 16'h0010 + 16'(i)); end
    end
    rd_en = 1'b0;
    clr = 1'b1; step(); clr = 1'b0;
    wr_en = 1'b1; rd_en = 1'b1; wdata = 16'h55AA;
    step();
    wr_en = 1'b0;
    compared++; if (count !== 4'd1 || underflow !== 1'b1) begin mismatched++; $display("FAIL simempty got c=%0d u=%b want c=1 u=1", count, underflow); end
    compared++; if (rvalid !== 1'b0 || rdata !== 16'h0018) begin mismatched++; $display("FAIL simempty_rv got v=%b d=%h want v=0 d=0018", rvalid, rdata); end
    step();
    rd_en = 1'b0;
    compared++; if (rvalid !== 1'b1 || rdata !== 16'h55AA || count !== 4'd0) begin mismatched++; $display("FAIL simempty_read got v=%b d=%h c=%0d want v=1 d=55aa c=0", rvalid, rdata, count); end
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin wr_en = 1'b1; wdata = 16'(100 + i); step(); end
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wdata = 16'(103 + k);
      step();
      compared++; if (count !== 4'd3) begin mismatched++; $display("FAIL wrap_count[%0d] got %0d want 3", k, count); end
      compared++; if (rvalid !== 1'b1 || rdata !== 16'(100 + k)) begin mismatched++; $display("FAIL wrap_data[%0d] got v=%b d=%0d want v=1 d=%0d", k, rvalid, rdata, 100 + k); end
    end
    wr_en = 1'b0;
    for (int k = 20; k < 23; k++) begin
      step();
      compared++; if (rdata !== 16'(100 + k)) begin mismatched++; $display("FAIL wrap_tail[%0d] got %0d want %0d", k, rdata, 100 + k); end
    end
    rd_en = 1'b0;
    step();
    compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL wrap_empty got %b want 1", empty); end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) begin wr_en = 1'b1; wdata = 16'h0200 + 16'(i); step(); end
    compared++; if (count !== 4'd5) begin mismatched++; $display("FAIL pre_flush got %0d want 5", count); end
    wr_en = 1'b1; clr = 1'b1; wdata = 16'h0F00;
    step();
    wr_en = 1'b0; clr = 1'b0;
    compared++; if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0) begin mismatched++; $display("FAIL flush got c=%0d e=%b o=%b want c=0 e=1 o=0", count, empty, overflow); end
    compared++; if (rdata !== 16'd122 || rvalid !== 1'b0) begin mismatched++; $display("FAIL flush_hold got d=%0d v=%b want d=122 v=0", rdata, rvalid); end
    step();
    compared++; if (count !== 4'd0) begin mismatched++; $display("FAIL flush_nowrite got %0d want 0", count); end
    rd_en = 1'b1; step();
    compared++; if (underflow !== 1'b1) begin mismatched++; $display("FAIL pre_rst_udf got %b want 1", underflow); end
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin wdata = 16'h0300 + 16'(i); step(); end
    compared++; if (rvalid !== 1'b1 || count === 4'd0) begin mismatched++; $display("FAIL pre_rst_busy got v=%b c=%0d want v=1 c>0", rvalid, count); end
    #3 rst = 1'b1;
    #1;
    compared++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin mismatched++; $display("FAIL arst_count got c=%0d e=%b f=%b want c=0 e=1 f=0", count, empty, full); end
    compared++; if (rvalid !== 1'b0 || rdata !== 16'h0 || underflow !== 1'b0 || overflow !== 1'b0) begin mismatched++; $display("FAIL arst_out got v=%b d=%h u=%b o=%b want 0 0000 0 0", rvalid, rdata, underflow, overflow); end
    idle();
    #1 rst = 1'b0;
    step();
    compared++; if (empty !== 1'b1 || aempty !== 1'b1 || rvalid !== 1'b0) begin mismatched++; $display("FAIL post_rst got e=%b ae=%b v=%b want 1 1 0", empty, aempty, rvalid); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_errors();
    test_simul_boundary();
    test_wrap();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
